binary_mul_param_bi: RTL and testbench

BINARY_MUL_PARAM_BI -- requirements
Module: binary_mul_param_bi

---
 rtl/binary_mul_param_bi.sv | 208 ++++++++++++++++++++
 tb/tb_binary_mul_param_bi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_mul_param_bi.sv
// ---------------------------------------------------------------------------
// binary_mul_param_bi
//
// Iterative shift-add multiplier for signed (two's-complement) or unsigned
// operands. One operand pair is accepted in IDLE. The block then retires
// BITS_PER_CYCLE multiplier bits per enabled clock in RUN. The finished
// 2*WIDTH-bit product is held in DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where en=1 and both valid
// and ready are high. This applies to in_valid/in_ready on the input side
// and to out_valid/out_ready on the output side. valid never depends on
// ready in the same cycle, and en=0 blocks every transfer.
//
// Optional feature (macro BINARY_MUL_ACC_EN): adds input 'acc'. It is sampled
// at accept. acc=1 makes the result P_prev + A*B modulo 2^(2*WIDTH).
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   global clock enable (0 freezes all state)
//   in_valid     in   A, B, signed_mode presented
//   in_ready     out  block can accept operands (IDLE only)
//   A            in   [WIDTH-1:0] multiplicand
//   B            in   [WIDTH-1:0] multiplier
//   signed_mode  in   1 = two's-complement, 0 = unsigned
//   P            out  [2*WIDTH-1:0] registered product
//   out_valid    out  P holds a finished result (DONE)
//   out_ready    in   consumer takes P
//   busy         out  high in RUN and DONE
//   acc          in   (BINARY_MUL_ACC_EN only) accumulate into previous P
//   dbg_state    out  [1:0] current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module binary_mul_param_bi #(
  parameter int WIDTH          = 14,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic [2*WIDTH-1:0]   P,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
`ifdef BINARY_MUL_ACC_EN
  input  logic                 acc,
`endif
  output logic [1:0]           dbg_state
);

  // -------------------------------------------------------------------------
  // Parameter legality, checked at elaboration
  // -------------------------------------------------------------------------
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("binary_mul_param_bi: WIDTH must be in 4..32");
  end
  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bpc
    $error("binary_mul_param_bi: BITS_PER_CYCLE must be 1 or 2");
  end
  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_div
    $error("binary_mul_param_bi: WIDTH must be divisible by BITS_PER_CYCLE");
  end

  localparam int PW    = 2 * WIDTH;
  localparam int NITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(NITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   mcand_q, mcand_d;   // multiplicand, extended, shifted left
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right
  logic            sign_q, sign_d;
  logic [PW-1:0]   sum_q, sum_d;       // running partial-product sum
  logic [PW-1:0]   p_q, p_d;

  logic            accept;
  logic            last_iter;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   sum_next;
  logic            acc_sel;

`ifdef BINARY_MUL_ACC_EN
  assign acc_sel = acc;
`else
  assign acc_sel = 1'b0;
`endif

  assign accept    = en && in_valid && (state_q == S_IDLE);
  assign last_iter = (cnt_q == CW'(1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)                state_d = S_RUN;
      S_RUN:  if (en && last_iter)       state_d = S_DONE;
      S_DONE: if (en && out_ready)       state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (in_ready reflects state even while en=0)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    out_valid = (state_q == S_DONE);
    dbg_state = state_q;
    P         = p_q;
  end

  // -------------------------------------------------------------------------
  // Partial product for the bits retired this iteration.
  // In signed mode the multiplier MSB carries weight -2^(WIDTH-1). That bit
  // sits at position BITS_PER_CYCLE-1 on the final iteration, so its term is
  // subtracted instead of added. The multiplicand is already sign-extended,
  // so a negative A needs no special case.
  // -------------------------------------------------------------------------
  always_comb begin
    partial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) begin
        if (sign_q && last_iter && (k == BITS_PER_CYCLE - 1)) begin
          partial = partial - (mcand_q << k);
        end else begin
          partial = partial + (mcand_q << k);
        end
      end
    end
    sum_next = sum_q + partial;
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    sum_d    = sum_q;
    p_d      = p_q;

    if (accept) begin
      cnt_d    = CW'(NITER);
      mcand_d  = {{WIDTH{signed_mode & A[WIDTH-1]}}, A};
      mplier_d = B;
      sign_d   = signed_mode;
      // Accumulation seeds the sum with the current product register, so the
      // wrap modulo 2^(2*WIDTH) falls out of the adder width.
      sum_d    = acc_sel ? p_q : '0;
    end else if (en && (state_q == S_RUN)) begin
      cnt_d    = cnt_q - CW'(1);
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      sum_d    = sum_next;
      if (last_iter) begin
        p_d = sum_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      sum_q    <= '0;
      p_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      sum_q    <= sum_d;
      p_q      <= p_d;
    end
  end

endmodule

// File: tb/tb_binary_mul_param_bi.sv
// ---------------------------------------------------------------------------
// Bench for binary_mul_param_bi. Two instances share one set of inputs:
// dut1 uses the default parameters (WIDTH=14, BITS_PER_CYCLE=1) and dut2 uses
// WIDTH=14, BITS_PER_CYCLE=2. Results come from an arithmetic reference
// model. Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_binary_mul_param_bi;

  localparam int W  = 14;
  localparam int PW = 2 * W;
`ifdef BINARY_MUL_ACC_EN
  localparam bit ACC_BUILD = 1'b1;
`else
  localparam bit ACC_BUILD = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset / signals
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic signed_mode = 1'b0;
  logic out_ready = 1'b0;
  logic acc_in = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;

  logic [PW-1:0] p1, p2;
  logic ir1, ir2, ov1, ov2, bz1, bz2;
  logic [1:0] st1, st2;

  int total = 0;
  int bad = 0;
  logic [PW-1:0] model_p = '0;  // model of the P register (same for both)

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  binary_mul_param_bi #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir1),
    .A(a_in), .B(b_in), .signed_mode(signed_mode), .P(p1), .out_valid(ov1),
    .out_ready(out_ready), .busy(bz1),
`ifdef BINARY_MUL_ACC_EN
    .acc(acc_in),
`endif
    .dbg_state(st1)
  );

  binary_mul_param_bi #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir2),
    .A(a_in), .B(b_in), .signed_mode(signed_mode), .P(p2), .out_valid(ov2),
    .out_ready(out_ready), .busy(bz2),
`ifdef BINARY_MUL_ACC_EN
    .acc(acc_in),
`endif
    .dbg_state(st2)
  );

  // -------------------------------------------------------------------------
  // Reference model: exact integer product, truncated to 2*W bits
  // -------------------------------------------------------------------------
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sm, input logic ac,
                                            input logic [PW-1:0] prev);
    longint sa, sb, prod;
    logic [PW-1:0] r;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    prod = sa * sb;
    r = prod[PW-1:0];
    if (ACC_BUILD && ac) r = r + prev;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // One transaction through both instances.
  // en_mode: 0 = en always 1, 1 = random en, 2 = en low for 3 cycles mid-RUN
  // hold:    cycles to keep out_ready=0 after both results are valid
  // -------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic ac, input int en_mode, input int hold, input string tag);
    logic [PW-1:0] exp;
    int en_edges, raw_edges, done1, done2, raw1, raw2;
    exp = ref_mul(a, b, sm, ac, model_p);
    @(negedge clk);
    total++;
    if (ir1 !== 1'b1 || ir2 !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_pre: in_ready got %b/%b want 1/1", tag, ir1, ir2);
    end
    en = 1'b1; in_valid = 1'b1; a_in = a; b_in = b; signed_mode = sm; acc_in = ac;
    @(negedge clk);
    // Scramble operands after accept; the in-flight result must not change.
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
    signed_mode = 1'($urandom_range(0, 1)); acc_in = 1'($urandom_range(0, 1));
    total++;
    if (bz1 !== 1'b1 || bz2 !== 1'b1 || ir1 !== 1'b0 || ir2 !== 1'b0 || ov1 !== 1'b0 || ov2 !== 1'b0) begin
      bad++;
      $display("FAIL %s_accept: busy=%b/%b in_ready=%b/%b out_valid=%b/%b want 1/1 0/0 0/0",
               tag, bz1, bz2, ir1, ir2, ov1, ov2);
    end
    en_edges = 0; raw_edges = 0; done1 = -1; done2 = -1; raw1 = -1; raw2 = -1;
    for (int cyc = 0; cyc < 400 && (done1 < 0 || done2 < 0); cyc++) begin
      case (en_mode)
        1:       en = ($urandom_range(0, 3) != 0);
        2:       en = !(cyc >= 3 && cyc <= 5);
        default: en = 1'b1;
      endcase
      in_valid = 1'($urandom_range(0, 1));  // must be ignored while busy
      a_in = W'($urandom); b_in = W'($urandom);
      @(negedge clk);
      raw_edges++;
      if (en) en_edges++;
      if (ov1 === 1'b1 && done1 < 0) begin done1 = en_edges; raw1 = raw_edges; end
      if (ov2 === 1'b1 && done2 < 0) begin done2 = en_edges; raw2 = raw_edges; end
      if (done1 < 0) begin
        total++;
        if (p1 !== model_p) begin
          bad++;
          $display("FAIL %s_p_hold_run: P got %h want %h", tag, p1, model_p);
        end
      end
    end
    en = 1'b1; in_valid = 1'b0;
    total++;
    if (done1 != W) begin
      bad++;
      $display("FAIL %s_latency1: enabled edges got %0d want %0d", tag, done1, W);
    end
    total++;
    if (done2 != W / 2) begin
      bad++;
      $display("FAIL %s_latency2: enabled edges got %0d want %0d", tag, done2, W / 2);
    end
    if (en_mode == 2) begin
      total++;
      if (raw1 != W + 3 || raw2 != W / 2 + 3) begin
        bad++;
        $display("FAIL %s_stall_latency: raw edges got %0d/%0d want %0d/%0d",
                 tag, raw1, raw2, W + 3, W / 2 + 3);
      end
    end
    total++;
    if (p1 !== exp || p2 !== exp) begin
      bad++;
      $display("FAIL %s_product: P got %h/%h want %h", tag, p1, p2, exp);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a_in = W'($urandom); b_in = W'($urandom);
      @(negedge clk);
      total++;
      if (ov1 !== 1'b1 || ov2 !== 1'b1 || ir1 !== 1'b0 || ir2 !== 1'b0 ||
          p1 !== exp || p2 !== exp) begin
        bad++;
        $display("FAIL %s_backpressure: ov=%b/%b ir=%b/%b P=%h/%h want 1/1 0/0 %h",
                 tag, ov1, ov2, ir1, ir2, p1, p2, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (ov1 !== 1'b0 || ov2 !== 1'b0 || ir1 !== 1'b1 || ir2 !== 1'b1 ||
        st1 !== 2'd0 || st2 !== 2'd0 || p1 !== exp || p2 !== exp) begin
      bad++;
      $display("FAIL %s_release: ov=%b/%b ir=%b/%b st=%0d/%0d P=%h/%h want 0/0 1/1 0/0 %h",
               tag, ov1, ov2, ir1, ir2, st1, st2, p1, p2, exp);
    end
    model_p = exp;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (p1 !== '0 || p2 !== '0 || ir1 !== 1'b1 || ir2 !== 1'b1 || ov1 !== 1'b0 ||
        ov2 !== 1'b0 || bz1 !== 1'b0 || bz2 !== 1'b0 || st1 !== 2'd0 || st2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: P=%h/%h ir=%b/%b ov=%b/%b busy=%b/%b st=%0d/%0d",
               p1, p2, ir1, ir2, ov1, ov2, bz1, bz2, st1, st2);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_p = '0;
  endtask

  task automatic test_directed();
    run_op(14'h2000, 14'h2000, 1'b1, 1'b0, 0, 0, "min_x_min");   // 67108864
    total++;
    if (p1 !== 28'd67108864) begin
      bad++;
      $display("FAIL min_x_min_value: P got %0d want 67108864", p1);
    end
    run_op(14'h3FFF, 14'h3FFF, 1'b0, 1'b0, 0, 0, "umax_sq");     // 268402689
    total++;
    if (p1 !== 28'd268402689) begin
      bad++;
      $display("FAIL umax_sq_value: P got %0d want 268402689", p1);
    end
    run_op(14'h3FFF, 14'h0001, 1'b1, 1'b0, 0, 0, "neg1_x_1");    // -1
    run_op(14'h3FDB, 14'd125, 1'b1, 1'b0, 0, 0, "m37_x_125");    // -4625
    total++;
    if (p2 !== 28'hFFFEDEF) begin
      bad++;
      $display("FAIL m37_x_125_value: P got %h want %h", p2, 28'hFFFEDEF);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1, 0, "random");
    end
  endtask

  task automatic test_en_stall();
    run_op(W'($urandom), W'($urandom), 1'b1, 1'b0, 2, 0, "en_stall");
  endtask

  task automatic test_backpressure();
    run_op(W'($urandom), W'($urandom), 1'b0, 1'b0, 0, 20, "bp");
    run_op(W'($urandom), W'($urandom), 1'b1, 1'b0, 0, 0, "after_bp");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    en = 1'b1; in_valid = 1'b1; a_in = 14'h2000; b_in = 14'h2000;
    signed_mode = 1'b1; acc_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (p1 !== '0 || p2 !== '0 || ir1 !== 1'b1 || ir2 !== 1'b1 || ov1 !== 1'b0 ||
        ov2 !== 1'b0 || bz1 !== 1'b0 || bz2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: P=%h/%h ir=%b/%b ov=%b/%b busy=%b/%b want 0 1 0 0",
               p1, p2, ir1, ir2, ov1, ov2, bz1, bz2);
    end
    model_p = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (ov1 !== 1'b0 || ov2 !== 1'b0 || p1 !== '0) begin
        bad++;
        $display("FAIL reset_discard: ov=%b/%b P=%h want 0/0 0", ov1, ov2, p1);
      end
    end
    run_op(14'd7, 14'd9, 1'b0, 1'b0, 0, 0, "post_reset");
  endtask

`ifdef BINARY_MUL_ACC_EN
  task automatic test_acc();
    run_op(14'd3, 14'd4, 1'b0, 1'b0, 0, 0, "acc_first");
    run_op(14'd5, 14'd6, 1'b0, 1'b1, 0, 0, "acc_second");
    total++;
    if (p1 !== 28'd42 || p2 !== 28'd42) begin
      bad++;
      $display("FAIL acc_value: P got %0d/%0d want 42", p1, p2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_en_stall();
    test_backpressure();
    test_random();
    test_reset_mid_run();
`ifdef BINARY_MUL_ACC_EN
    test_acc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
